inst_encoder_loader: RTL and testbench
======================================

Name: inst_encoder_loader

Overview:
Programme-loading encoder for the 19-bit pP instruction set. It accepts one instruction per handshake as decoded fields (kind plus operand fields), packs them into the 19-bit instruction word, and writes the words to instruction memory at sequential addresses. It sits between the debug/host loader path and the IMEM write port, and is the exact inverse of the pP instruction decoder's field map.

Parameters:
BASE_DEFAULT, 12'h000, IMEM address loaded by start when start_addr_sel=0

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; arms the loader (honoured only in IDLE/DONE)
start_addr_sel  input  1  1: use start_addr; 0: use BASE_DEFAULT
start_addr  input  12  first IMEM address
in_valid  input  1  field bundle valid
in_ready  output  1  loader accepts a bundle this cycle
in_last  input  1  bundle is the final instruction of the programme
kind  input  4  instruction kind, decoder encoding 0..10
fn3  input  3  ALU function (kinds 0,1)
fn2  input  2  sub-function (kinds 2,3,4)
waddr  input  3  destination register (kinds 0-3)
raddr1  input  3  source register 1 (kinds 0-3)
raddr2  input  3  source register 2 (kind 0)
imm  input  8  immediate constant (kind 1)
sc  input  3  shift count (kind 2)
disp  input  8  displacement (kinds 3,4)
jaddr  input  12  jump target (kinds 5,6)
imem_we  output  1  IMEM write request
imem_addr  output  12  IMEM write address
imem_wdata  output  19  encoded instruction
imem_ack  input  1  IMEM write accepted
err  output  1  one-cycle pulse: illegal kind, bundle dropped
done  output  1  level: programme complete
ovf  output  1  level: address space exhausted (wrote 12'hFFF)
count  output  13  words written since last start

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, err=0, done=0, ovf=0, count=0. Reset mid-write abandons the write immediately.
- States: IDLE, READY, ENC, WR, DONE.
- IDLE/DONE: on start, load imem_addr, clear count/done/ovf, go to READY. in_valid is ignored and in_ready=0.
- READY: in_ready=1. When in_valid=1, capture all fields and in_last, then go to ENC. start is ignored.
- ENC, one cycle: build the word; unused bits and fields are 0.
  - kind0: {00,fn3,waddr,raddr1,raddr2,5'b0}
  - kind1: {01,fn3,waddr,raddr1,imm}
  - kind2: {110,fn2,waddr,raddr1,sc,5'b0}
  - kind3: {100,fn2,waddr,raddr1,disp}
  - kind4: {101,fn2,6'b0,disp}
  - kind5: {11100,2'b0,jaddr}
  - kind6: {11101,2'b0,jaddr}
  - kind7: {111100,13'b0}
  - kind8: {111101,13'b0}
  - kind9: {111110,13'b0}
  - kind10: {111111,13'b0}
  - Legal kind: load imem_wdata and go to WR.
  - Kind 11-15: err=1 for this cycle, no write, address and count unchanged. If the captured in_last=1, go to DONE; otherwise go to READY.
- WR: imem_we=1; imem_addr and imem_wdata held stable until imem_ack. imem_ack is sampled only in WR, and may arrive in the first WR cycle.
  - On ack: imem_we drops next cycle and count increments.
  - If imem_addr==12'hFFF: set ovf, go to DONE, imem_addr wraps to 0.
  - Else if last: go to DONE, imem_addr increments.
  - Else: go to READY, imem_addr increments.
- Latency: bundle accepted at edge t, imem_we high from t+2; next in_ready no earlier than one cycle after ack.
- Throughput is one instruction per 3 cycles minimum (READY, ENC, WR with same-cycle ack).
- done is high throughout DONE.

Test Plan:
- start (start_addr_sel=1, start_addr=12'h010); kind0 fn3=5 waddr=2 raddr1=3 raddr2=7 -> imem_we at t+2, imem_addr=12'h010, imem_wdata=19'h153E0; count=1.
- kind6 jaddr=12'hABC with fn3/imm driven nonzero -> imem_wdata=19'h74ABC (unused fields masked). Then kind8 with in_last=1 -> 19'h7A000 at next address, done=1, in_ready=0.
- kind4 fn2=2 disp=8'h80, imem_ack held low 5 cycles -> imem_we and imem_wdata=19'h58080 stable for all 6 WR cycles, single count increment.
- kind=4'hC -> err pulse exactly 1 cycle, imem_we never asserted, imem_addr and count unchanged, in_ready returns.
- start_addr=12'hFFE, two legal bundles without in_last -> writes at FFE and FFF, then ovf=1, done=1, imem_addr=0, count=2; further in_valid not accepted.
- rst_n low while in WR with imem_we=1 -> imem_we drops asynchronously, all outputs at reset values; the loader stays IDLE until the next start.

Source files
------------

// File: rtl/inst_encoder_loader.sv
// Programme loader for the 19-bit pP instruction set: packs decoded field
// bundles into instruction words and writes them to IMEM at sequential addresses.
module inst_encoder_loader #(
    parameter logic [11:0] BASE_DEFAULT = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        start_addr_sel,
    input  logic [11:0] start_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [3:0]  kind,
    input  logic [2:0]  fn3,
    input  logic [1:0]  fn2,
    input  logic [2:0]  waddr,
    input  logic [2:0]  raddr1,
    input  logic [2:0]  raddr2,
    input  logic [7:0]  imm,
    input  logic [2:0]  sc,
    input  logic [7:0]  disp,
    input  logic [11:0] jaddr,
    output logic        imem_we,
    output logic [11:0] imem_addr,
    output logic [18:0] imem_wdata,
    input  logic        imem_ack,
    output logic        err,
    output logic        done,
    output logic        ovf,
    output logic [12:0] count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READY = 3'd1;
    localparam logic [2:0] S_ENC   = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]  state;
    logic [3:0]  kind_q;
    logic [2:0]  fn3_q;
    logic [1:0]  fn2_q;
    logic [2:0]  waddr_q;
    logic [2:0]  raddr1_q;
    logic [2:0]  raddr2_q;
    logic [7:0]  imm_q;
    logic [2:0]  sc_q;
    logic [7:0]  disp_q;
    logic [11:0] jaddr_q;
    logic        last_q;

    logic [18:0] word;
    logic        legal;

    // Inverse of the decoder field map; every bit not named by a kind stays 0.
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (kind_q)
            4'd0:    word = {2'b00, fn3_q, waddr_q, raddr1_q, raddr2_q, 5'b0};
            4'd1:    word = {2'b01, fn3_q, waddr_q, raddr1_q, imm_q};
            4'd2:    word = {3'b110, fn2_q, waddr_q, raddr1_q, sc_q, 5'b0};
            4'd3:    word = {3'b100, fn2_q, waddr_q, raddr1_q, disp_q};
            4'd4:    word = {3'b101, fn2_q, 6'b0, disp_q};
            4'd5:    word = {5'b11100, 2'b0, jaddr_q};
            4'd6:    word = {5'b11101, 2'b0, jaddr_q};
            4'd7:    word = {6'b111100, 13'b0};
            4'd8:    word = {6'b111101, 13'b0};
            4'd9:    word = {6'b111110, 13'b0};
            4'd10:   word = {6'b111111, 13'b0};
            default: legal = 1'b0;
        endcase
    end

    // Decoded from state so an asynchronous reset drops the write request at once.
    assign in_ready = (state == S_READY);
    assign imem_we  = (state == S_WR);
    assign done     = (state == S_DONE);
    assign err      = (state == S_ENC) && !legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            imem_addr  <= '0;
            imem_wdata <= '0;
            ovf        <= 1'b0;
            count      <= '0;
            kind_q     <= '0;
            fn3_q      <= '0;
            fn2_q      <= '0;
            waddr_q    <= '0;
            raddr1_q   <= '0;
            raddr2_q   <= '0;
            imm_q      <= '0;
            sc_q       <= '0;
            disp_q     <= '0;
            jaddr_q    <= '0;
            last_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        imem_addr <= start_addr_sel ? start_addr : BASE_DEFAULT;
                        count     <= '0;
                        ovf       <= 1'b0;
                        state     <= S_READY;
                    end
                end
                S_READY: begin
                    if (in_valid) begin
                        kind_q   <= kind;
                        fn3_q    <= fn3;
                        fn2_q    <= fn2;
                        waddr_q  <= waddr;
                        raddr1_q <= raddr1;
                        raddr2_q <= raddr2;
                        imm_q    <= imm;
                        sc_q     <= sc;
                        disp_q   <= disp;
                        jaddr_q  <= jaddr;
                        last_q   <= in_last;
                        state    <= S_ENC;
                    end
                end
                S_ENC: begin
                    if (legal) begin
                        imem_wdata <= word;
                        state      <= S_WR;
                    end else begin
                        state <= last_q ? S_DONE : S_READY;
                    end
                end
                S_WR: begin
                    if (imem_ack) begin
                        count     <= count + 13'd1;
                        imem_addr <= imem_addr + 12'd1;
                        if (imem_addr == 12'hFFF) begin
                            ovf   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= last_q ? S_DONE : S_READY;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed, table-driven bench for inst_encoder_loader with hand-computed words.
module tb_inst_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start_addr_sel = 1'b0;
    logic [11:0] start_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [3:0]  kind = '0;
    logic [2:0]  fn3 = '0;
    logic [1:0]  fn2 = '0;
    logic [2:0]  waddr = '0;
    logic [2:0]  raddr1 = '0;
    logic [2:0]  raddr2 = '0;
    logic [7:0]  imm = '0;
    logic [2:0]  sc = '0;
    logic [7:0]  disp = '0;
    logic [11:0] jaddr = '0;
    logic        imem_we;
    logic [11:0] imem_addr;
    logic [18:0] imem_wdata;
    logic        imem_ack = 1'b0;
    logic        err;
    logic        done;
    logic        ovf;
    logic [12:0] count;

    inst_encoder_loader #(.BASE_DEFAULT(12'h000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr_sel(start_addr_sel),
        .start_addr(start_addr), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .kind(kind), .fn3(fn3), .fn2(fn2), .waddr(waddr),
        .raddr1(raddr1), .raddr2(raddr2), .imm(imm), .sc(sc), .disp(disp),
        .jaddr(jaddr), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_ack(imem_ack), .err(err), .done(done),
        .ovf(ovf), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  kind;
        logic [2:0]  fn3;
        logic [1:0]  fn2;
        logic [2:0]  waddr;
        logic [2:0]  raddr1;
        logic [2:0]  raddr2;
        logic [7:0]  imm;
        logic [2:0]  sc;
        logic [7:0]  disp;
        logic [11:0] jaddr;
        logic        last;
        int          stall;
        logic [18:0] word;
        logic        bad;
    } vec_t;

    int          n_chk = 0;
    int          n_bad = 0;
    logic [11:0] exp_addr;
    logic [12:0] exp_cnt;
    logic        exp_ovf;
    vec_t        vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] k, input logic [2:0] f3, input logic [1:0] f2,
                                input logic [2:0] wa, input logic [2:0] r1, input logic [2:0] r2,
                                input logic [7:0] im, input logic [2:0] s, input logic [7:0] d,
                                input logic [11:0] ja, input logic l, input int st,
                                input logic [18:0] w, input logic b);
        vec_t v;
        v.kind = k; v.fn3 = f3; v.fn2 = f2; v.waddr = wa; v.raddr1 = r1; v.raddr2 = r2;
        v.imm = im; v.sc = s; v.disp = d; v.jaddr = ja; v.last = l; v.stall = st;
        v.word = w; v.bad = b;
        return v;
    endfunction

    task automatic do_start(input logic sel, input logic [11:0] a, input logic [11:0] exp_base);
        @(negedge clk);
        start = 1'b1; start_addr_sel = sel; start_addr = a;
        @(negedge clk);
        start = 1'b0;
        exp_addr = exp_base; exp_cnt = '0; exp_ovf = 1'b0;
        chk("start_addr", imem_addr, exp_base);
        chk("start_ready", in_ready, 1);
        chk("start_count", count, 0);
        chk("start_ovf", ovf, 0);
    endtask

    task automatic send(input vec_t v);
        int n;
        @(negedge clk);
        kind = v.kind; fn3 = v.fn3; fn2 = v.fn2; waddr = v.waddr; raddr1 = v.raddr1;
        raddr2 = v.raddr2; imm = v.imm; sc = v.sc; disp = v.disp; jaddr = v.jaddr;
        in_last = v.last; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", n < 20, 1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("enc_we", imem_we, 0);
        chk("enc_err", err, v.bad);
        if (v.bad) begin
            @(negedge clk);
            chk("err_pulse", err, 0);
            chk("err_we", imem_we, 0);
            chk("err_addr", imem_addr, exp_addr);
            chk("err_count", count, exp_cnt);
            chk("err_ready", in_ready, !v.last);
            return;
        end
        @(negedge clk);
        for (int i = 0; i <= v.stall; i++) begin
            chk("wr_we", imem_we, 1);
            chk("wr_addr", imem_addr, exp_addr);
            chk("wr_data", imem_wdata, v.word);
            chk("wr_count", count, exp_cnt);
            if (i == v.stall) imem_ack = 1'b1;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        if (exp_addr == 12'hFFF) exp_ovf = 1'b1;
        exp_addr = exp_addr + 12'd1;
        exp_cnt = exp_cnt + 13'd1;
        chk("post_we", imem_we, 0);
        chk("post_addr", imem_addr, exp_addr);
        chk("post_count", count, exp_cnt);
        chk("post_ovf", ovf, exp_ovf);
        chk("post_done", done, v.last || exp_ovf);
        chk("post_ready", in_ready, !(v.last || exp_ovf));
    endtask

    task automatic refuse_input();
        @(negedge clk);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("refuse_ready", in_ready, 0);
            chk("refuse_we", imem_we, 0);
            chk("refuse_count", count, exp_cnt);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        // Unused fields carry nonzero junk so masking is exercised.
        vecs[0]  = mk(4'd0,  3'd5, 2'd3, 3'd2, 3'd3, 3'd7, 8'hFF, 3'd7, 8'hAA, 12'hFFF, 1'b0, 0, 19'h153E0, 1'b0);
        vecs[1]  = mk(4'd1,  3'd3, 2'd2, 3'd1, 3'd4, 3'd6, 8'h5A, 3'd5, 8'h11, 12'h0F0, 1'b0, 1, 19'h2CC5A, 1'b0);
        vecs[2]  = mk(4'd2,  3'd6, 2'd1, 3'd7, 3'd2, 3'd5, 8'h33, 3'd5, 8'h77, 12'h555, 1'b0, 0, 19'h67AA0, 1'b0);
        vecs[3]  = mk(4'd3,  3'd7, 2'd3, 3'd5, 3'd6, 3'd1, 8'h44, 3'd2, 8'hC3, 12'hAAA, 1'b0, 2, 19'h4EEC3, 1'b0);
        vecs[4]  = mk(4'd4,  3'd7, 2'd2, 3'd7, 3'd7, 3'd7, 8'hFF, 3'd7, 8'h80, 12'hFFF, 1'b0, 5, 19'h58080, 1'b0);
        vecs[5]  = mk(4'hC,  3'd1, 2'd1, 3'd1, 3'd1, 3'd1, 8'h01, 3'd1, 8'h01, 12'h001, 1'b0, 0, 19'h00000, 1'b1);
        vecs[6]  = mk(4'd5,  3'd4, 2'd3, 3'd6, 3'd5, 3'd3, 8'h99, 3'd6, 8'h66, 12'h123, 1'b0, 0, 19'h70123, 1'b0);
        vecs[7]  = mk(4'd6,  3'd7, 2'd3, 3'd3, 3'd3, 3'd3, 8'hFF, 3'd3, 8'hFF, 12'hABC, 1'b0, 0, 19'h74ABC, 1'b0);
        vecs[8]  = mk(4'd7,  3'd7, 2'd3, 3'd7, 3'd7, 3'd7, 8'hFF, 3'd7, 8'hFF, 12'hFFF, 1'b0, 0, 19'h78000, 1'b0);
        vecs[9]  = mk(4'd9,  3'd2, 2'd1, 3'd4, 3'd2, 3'd1, 8'h12, 3'd3, 8'h34, 12'h567, 1'b0, 1, 19'h7C000, 1'b0);
        vecs[10] = mk(4'd10, 3'd1, 2'd2, 3'd3, 3'd4, 3'd5, 8'h21, 3'd4, 8'h43, 12'h765, 1'b0, 0, 19'h7E000, 1'b0);
        vecs[11] = mk(4'hF,  3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 8'h00, 3'd0, 8'h00, 12'h000, 1'b0, 0, 19'h00000, 1'b1);
        vecs[12] = mk(4'd8,  3'd5, 2'd1, 3'd2, 3'd6, 3'd4, 8'hAB, 3'd6, 8'hCD, 12'hEF0, 1'b1, 0, 19'h7A000, 1'b0);

        exp_addr = '0; exp_cnt = '0; exp_ovf = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_err", err, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_count", count, 0);
        rst_n = 1'b1;
        refuse_input();

        do_start(1'b1, 12'h010, 12'h010);
        foreach (vecs[i]) send(vecs[i]);
        chk("prog_count", count, 13'd11);
        chk("prog_addr", imem_addr, 12'h01B);
        refuse_input();

        // Address-space exhaustion: writes at FFE and FFF, then wrap and stop.
        do_start(1'b1, 12'hFFE, 12'hFFE);
        send(vecs[0]);
        send(vecs[7]);
        chk("ovf_flag", ovf, 1);
        chk("ovf_done", done, 1);
        chk("ovf_addr", imem_addr, 0);
        chk("ovf_count", count, 2);
        refuse_input();

        // start_addr_sel=0 selects BASE_DEFAULT and clears ovf.
        do_start(1'b0, 12'h555, 12'h000);
        send(vecs[1]);

        // Asynchronous reset while a write is pending.
        @(negedge clk);
        kind = 4'd3; disp = 8'h01; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_we", imem_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", imem_we, 0);
        chk("arst_addr", imem_addr, 0);
        chk("arst_wdata", imem_wdata, 0);
        chk("arst_count", count, 0);
        chk("arst_ready", in_ready, 0);
        chk("arst_done", done, 0);
        chk("arst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        refuse_input();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
